// File: rtl/blake2b_wr_arb_pkg.sv
// Shared widths and helpers for the blake2b write arbiter.
// No logic of its own; no latency or backpressure.
// Widths match the blake2b core so engines wire straight in.
package blake2b_wr_arb_pkg;

    localparam int B2_DW = 256;
    localparam int B2_AW = 32;
    localparam int B2_TW = 4;
    localparam int SRC_W = 3;

    // Next round-robin start point after granting g among n requesters.
    function automatic logic [SRC_W-1:0] rr_advance(input logic [SRC_W-1:0] g, input int n);
        if (int'(g) == n - 1) return '0;
        return g + 1'b1;
    endfunction

endpackage

// File: rtl/blake2b_wr_fifo.sv
// Per-engine synchronous write FIFO holding {tag, addr, data}.
// dout is the head word, combinational; a push is visible one cycle later.
// A push while full is ignored unless a pop frees the slot in the same cycle.
module blake2b_wr_fifo
    import blake2b_wr_arb_pkg::*;
#(
    parameter int W     = B2_TW + B2_AW + B2_DW,
    parameter int DEPTH = 8
) (
    input  logic                   eclk,
    input  logic                   rstb,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          wr_en;
    logic          rd_en;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);
    assign dout  = mem[rd_ptr];

    always_ff @(posedge eclk or posedge rstb) begin
        if (rstb) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge eclk) begin
        if (wr_en) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/blake2b_wr_arb.sv
// Round-robin arbiter draining per-engine write FIFOs onto one memc command port.
// Push to earliest wvalid is 2 cycles; output is registered, 1 word/cycle aggregate.
// memc_cmd_full blocks pops; engines are stalled via registered per-FIFO fill level.
module blake2b_wr_arb
    import blake2b_wr_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DW         = B2_DW,
    parameter int AW         = B2_AW,
    parameter int TW         = B2_TW,
    parameter int FIFO_DEPTH = 8,
    parameter int HEADROOM   = 2
) (
    input  logic                  eclk,
    input  logic                  rstb,
    input  logic [NUM_REQ*DW-1:0] req_wdata,
    input  logic [NUM_REQ*TW-1:0] req_wtag,
    input  logic [NUM_REQ*AW-1:0] req_waddr,
    input  logic [NUM_REQ-1:0]    req_wvalid,
    output logic [NUM_REQ-1:0]    req_full,
    input  logic                  memc_cmd_full,
    output logic [DW-1:0]         wdata,
    output logic [TW-1:0]         wtag,
    output logic [AW-1:0]         waddr,
    output logic [SRC_W-1:0]      wsrc,
    output logic                  wvalid,
    output logic [NUM_REQ-1:0]    ovf_err
);

    localparam int EW = TW + AW + DW;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] FULL_LVL = CW'(FIFO_DEPTH - HEADROOM);

    logic [EW-1:0]      fifo_dout  [NUM_REQ];
    logic [CW-1:0]      fifo_count [NUM_REQ];
    logic [NUM_REQ-1:0] fifo_full;
    logic [NUM_REQ-1:0] fifo_empty;
    logic [NUM_REQ-1:0] pop_vec;

    logic [SRC_W-1:0]   rr_ptr;
    logic [SRC_W-1:0]   grant;
    logic               grant_vld;
    logic               pop_en;
    logic [EW-1:0]      grant_dat;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        blake2b_wr_fifo #(
            .W     (EW),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .eclk  (eclk),
            .rstb  (rstb),
            .push  (req_wvalid[gi]),
            .pop   (pop_vec[gi]),
            .din   ({req_wtag[gi*TW +: TW], req_waddr[gi*AW +: AW], req_wdata[gi*DW +: DW]}),
            .dout  (fifo_dout[gi]),
            .count (fifo_count[gi]),
            .full  (fifo_full[gi]),
            .empty (fifo_empty[gi])
        );
    end

    // First pass searches rr_ptr..NUM_REQ-1, second pass wraps to 0..rr_ptr-1.
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!grant_vld && !fifo_empty[j] && (SRC_W'(j) >= rr_ptr)) begin
                grant_vld = 1'b1;
                grant     = SRC_W'(j);
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!grant_vld && !fifo_empty[j]) begin
                grant_vld = 1'b1;
                grant     = SRC_W'(j);
            end
        end
    end

    assign pop_en = grant_vld && !memc_cmd_full;

    always_comb begin
        grant_dat = '0;
        pop_vec   = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (grant == SRC_W'(j)) begin
                grant_dat  = fifo_dout[j];
                pop_vec[j] = pop_en;
            end
        end
    end

    always_ff @(posedge eclk or posedge rstb) begin
        if (rstb) begin
            rr_ptr   <= '0;
            wvalid   <= 1'b0;
            wdata    <= '0;
            wtag     <= '0;
            waddr    <= '0;
            wsrc     <= '0;
            req_full <= '0;
            ovf_err  <= '0;
        end else begin
            for (int j = 0; j < NUM_REQ; j++) begin
                req_full[j] <= (fifo_count[j] >= FULL_LVL);
            end
            // A push to a full FIFO is only lost when no pop frees the slot.
            ovf_err <= ovf_err | (req_wvalid & fifo_full & ~pop_vec);
            wvalid  <= pop_en;
            if (pop_en) begin
                {wtag, waddr, wdata} <= grant_dat;
                wsrc                 <= grant;
                rr_ptr               <= rr_advance(grant, NUM_REQ);
            end
        end
    end

endmodule

// File: tb/tb_blake2b_wr_arb.sv
// Scenario bench for blake2b_wr_arb against a queue-based reference model.
module tb_blake2b_wr_arb;

    localparam int N     = 4;
    localparam int DW    = 256;
    localparam int AW    = 32;
    localparam int TW    = 4;
    localparam int DEPTH = 8;
    localparam int HR    = 2;

    typedef struct packed {
        logic [TW-1:0] tag;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic            tb_clk = 1'b0;
    logic            rstb;
    logic [N*DW-1:0] req_wdata;
    logic [N*TW-1:0] req_wtag;
    logic [N*AW-1:0] req_waddr;
    logic [N-1:0]    req_wvalid;
    logic [N-1:0]    req_full;
    logic            memc_cmd_full;
    logic [DW-1:0]   wdata;
    logic [TW-1:0]   wtag;
    logic [AW-1:0]   waddr;
    logic [2:0]      wsrc;
    logic            wvalid;
    logic [N-1:0]    ovf_err;

    always #5 tb_clk = ~tb_clk;

    blake2b_wr_arb #(
        .NUM_REQ(N), .DW(DW), .AW(AW), .TW(TW), .FIFO_DEPTH(DEPTH), .HEADROOM(HR)
    ) dut (
        .eclk          (tb_clk),
        .rstb          (rstb),
        .req_wdata     (req_wdata),
        .req_wtag      (req_wtag),
        .req_waddr     (req_waddr),
        .req_wvalid    (req_wvalid),
        .req_full      (req_full),
        .memc_cmd_full (memc_cmd_full),
        .wdata         (wdata),
        .wtag          (wtag),
        .waddr         (waddr),
        .wsrc          (wsrc),
        .wvalid        (wvalid),
        .ovf_err       (ovf_err)
    );

    // Reference model: one queue per engine plus the expected output register.
    wr_t        mq [N][$];
    int         rr;
    logic       exp_wvalid;
    logic [2:0] exp_wsrc;
    wr_t        exp_w;
    logic [N-1:0] exp_full;
    logic [N-1:0] exp_ovf;
    int checks;
    int errors;

    task automatic model_reset();
        for (int i = 0; i < N; i++) mq[i].delete();
        rr = 0;
        exp_wvalid = 1'b0;
        exp_wsrc = '0;
        exp_w = '0;
        exp_full = '0;
        exp_ovf = '0;
    endtask

    function automatic wr_t rand_word();
        wr_t w;
        w.tag  = 4'($urandom);
        w.addr = $urandom;
        for (int k = 0; k < DW / 32; k++) w.data[k*32 +: 32] = $urandom;
        return w;
    endfunction

    task automatic drive(input int i, input wr_t w);
        req_wvalid[i]          = 1'b1;
        req_wtag[i*TW +: TW]   = w.tag;
        req_waddr[i*AW +: AW]  = w.addr;
        req_wdata[i*DW +: DW]  = w.data;
    endtask

    task automatic idle();
        req_wvalid = '0;
    endtask

    // Advance one clock and apply the same cycle's rules to the model.
    task automatic step();
        int found;
        wr_t w;
        @(posedge tb_clk);
        for (int i = 0; i < N; i++) exp_full[i] = (mq[i].size() >= DEPTH - HR);
        found = -1;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (rr + k) % N;
            if (found < 0 && mq[idx].size() > 0) found = idx;
        end
        if (!memc_cmd_full && found >= 0) begin
            exp_w      = mq[found].pop_front();
            exp_wvalid = 1'b1;
            exp_wsrc   = 3'(found);
            rr         = (found + 1) % N;
        end else begin
            exp_wvalid = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            if (req_wvalid[i]) begin
                w.tag  = req_wtag[i*TW +: TW];
                w.addr = req_waddr[i*AW +: AW];
                w.data = req_wdata[i*DW +: DW];
                if (mq[i].size() < DEPTH) mq[i].push_back(w);
                else exp_ovf[i] = 1'b1;
            end
        end
        #1;
    endtask

    task automatic apply_reset();
        idle();
        memc_cmd_full = 1'b0;
        rstb = 1'b1;
        #1;
        model_reset();
        @(posedge tb_clk);
        #1;
        rstb = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge tb_clk);
        #1;
        model_reset();
        checks++;
        if ({wvalid, wsrc, wtag, waddr, wdata, req_full, ovf_err} !== '0) begin
            errors++;
            $display("FAIL reset_state vld=%b src=%0d addr=%h tag=%h full=%b ovf=%b, want all zero",
                     wvalid, wsrc, waddr, wtag, req_full, ovf_err);
        end
        rstb = 1'b0;
    endtask

    task automatic test_single();
        wr_t w;
        w = rand_word();
        w.addr = 32'h5A00_0040;
        drive(2, w);
        for (int c = 0; c < 3; c++) begin
            step();
            idle();
            checks++;
            if ({wvalid, wsrc, exp_w.tag, waddr, wdata, req_full, ovf_err} !==
                {exp_wvalid, exp_wsrc, wtag, exp_w.addr, exp_w.data, exp_full, exp_ovf}) begin
                errors++;
                $display("FAIL single_model c=%0d vld=%b src=%0d addr=%h tag=%h, want vld=%b src=%0d addr=%h tag=%h",
                         c, wvalid, wsrc, waddr, wtag, exp_wvalid, exp_wsrc, exp_w.addr, exp_w.tag);
            end
            checks++;
            if (c == 1 && {wvalid, waddr, wsrc} !== {1'b1, 32'h5A00_0040, 3'd2}) begin
                errors++;
                $display("FAIL single_issue vld=%b addr=%h src=%0d, want vld=1 addr=5a000040 src=2",
                         wvalid, waddr, wsrc);
            end else if (c != 1 && wvalid !== 1'b0) begin
                errors++;
                $display("FAIL single_quiet c=%0d vld=%b, want 0", c, wvalid);
            end
        end
    endtask

    task automatic test_all_four();
        apply_reset();
        for (int i = 0; i < N; i++) drive(i, rand_word());
        step();
        idle();
        for (int k = 0; k < N; k++) begin
            step();
            checks++;
            if ({wvalid, wsrc, wtag, waddr, wdata, req_full, ovf_err} !==
                {exp_wvalid, exp_wsrc, exp_w, exp_full, exp_ovf}) begin
                errors++;
                $display("FAIL four_model k=%0d vld=%b src=%0d addr=%h, want vld=%b src=%0d addr=%h",
                         k, wvalid, wsrc, waddr, exp_wvalid, exp_wsrc, exp_w.addr);
            end
            checks++;
            if ({wvalid, wsrc} !== {1'b1, 3'(k)}) begin
                errors++;
                $display("FAIL four_order k=%0d vld=%b src=%0d, want vld=1 src=%0d", k, wvalid, wsrc, k);
            end
        end
        // rr_ptr should be back at 0: engine 0 must win over engine 3.
        drive(3, rand_word());
        drive(0, rand_word());
        step();
        idle();
        for (int k = 0; k < 2; k++) begin
            step();
            checks++;
            if ({wvalid, wsrc} !== {1'b1, (k == 0) ? 3'd0 : 3'd3}) begin
                errors++;
                $display("FAIL four_rr_wrap k=%0d vld=%b src=%0d, want vld=1 src=%0d",
                         k, wvalid, wsrc, (k == 0) ? 0 : 3);
            end
        end
    endtask

    task automatic test_stall();
        logic [AW-1:0] addrs [$];
        wr_t w;
        int n;
        memc_cmd_full = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (c < 6) begin
                w = rand_word();
                addrs.push_back(w.addr);
                drive(0, w);
            end
            step();
            idle();
            checks++;
            if ({wvalid, req_full, ovf_err} !== {1'b0, exp_full, exp_ovf}) begin
                errors++;
                $display("FAIL stall_window c=%0d vld=%b full=%b ovf=%b, want vld=0 full=%b ovf=%b",
                         c, wvalid, req_full, ovf_err, exp_full, exp_ovf);
            end
        end
        checks++;
        if (req_full[0] !== 1'b1) begin
            errors++;
            $display("FAIL stall_req_full got=%b want=1", req_full[0]);
        end
        memc_cmd_full = 1'b0;
        n = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            checks++;
            if ({wvalid, wsrc, wtag, waddr, wdata, req_full, ovf_err} !==
                {exp_wvalid, exp_wsrc, exp_w, exp_full, exp_ovf}) begin
                errors++;
                $display("FAIL stall_model c=%0d vld=%b addr=%h full=%b, want vld=%b addr=%h full=%b",
                         c, wvalid, waddr, req_full, exp_wvalid, exp_w.addr, exp_full);
            end
            if (wvalid === 1'b1 && n < 6) begin
                checks++;
                if (waddr !== addrs[n]) begin
                    errors++;
                    $display("FAIL stall_order n=%0d addr=%h want=%h", n, waddr, addrs[n]);
                end
                n++;
            end
        end
        checks++;
        if (n != 6) begin
            errors++;
            $display("FAIL stall_count got=%0d want=6", n);
        end
    endtask

    task automatic test_overflow();
        int n;
        memc_cmd_full = 1'b1;
        for (int c = 0; c < 9; c++) begin
            drive(1, rand_word());
            step();
            idle();
            checks++;
            if ({ovf_err, req_full, wvalid} !== {exp_ovf, exp_full, 1'b0} || ovf_err[1] !== (c == 8)) begin
                errors++;
                $display("FAIL ovf_fill c=%0d ovf=%b full=%b vld=%b, want ovf=%b full=%b vld=0",
                         c, ovf_err, req_full, wvalid, exp_ovf, exp_full);
            end
        end
        memc_cmd_full = 1'b0;
        n = 0;
        for (int c = 0; c < 15; c++) begin
            step();
            if (wvalid === 1'b1) n++;
            checks++;
            if ({wvalid, wsrc, wtag, waddr, wdata, req_full, ovf_err} !==
                {exp_wvalid, exp_wsrc, exp_w, exp_full, exp_ovf}) begin
                errors++;
                $display("FAIL ovf_drain c=%0d vld=%b addr=%h ovf=%b, want vld=%b addr=%h ovf=%b",
                         c, wvalid, waddr, ovf_err, exp_wvalid, exp_w.addr, exp_ovf);
            end
        end
        checks++;
        if (n != 8 || ovf_err[1] !== 1'b1) begin
            errors++;
            $display("FAIL ovf_result drained=%0d ovf1=%b, want drained=8 ovf1=1", n, ovf_err[1]);
        end
    endtask

    task automatic test_stream();
        int same;
        logic [2:0] prev;
        apply_reset();
        same = 0;
        prev = 3'd7;
        for (int c = 0; c < 40; c++) begin
            idle();
            if (!exp_full[0]) drive(0, rand_word());
            if (!exp_full[3]) drive(3, rand_word());
            step();
            checks++;
            if ({wvalid, wsrc, wtag, waddr, wdata, req_full, ovf_err} !==
                {exp_wvalid, exp_wsrc, exp_w, exp_full, exp_ovf}) begin
                errors++;
                $display("FAIL stream_model c=%0d vld=%b src=%0d full=%b ovf=%b, want vld=%b src=%0d full=%b ovf=%b",
                         c, wvalid, wsrc, req_full, ovf_err, exp_wvalid, exp_wsrc, exp_full, exp_ovf);
            end
            if (c >= 1) begin
                if (wvalid !== 1'b1 || wsrc === prev) same++;
                prev = wsrc;
            end
        end
        idle();
        checks++;
        if (same != 0 || ovf_err !== '0) begin
            errors++;
            $display("FAIL stream_alternate breaks=%0d ovf=%b, want breaks=0 ovf=0", same, ovf_err);
        end
        for (int c = 0; c < 20; c++) begin
            step();
            checks++;
            if ({wvalid, wsrc, wtag, waddr, wdata, req_full} !== {exp_wvalid, exp_wsrc, exp_w, exp_full}) begin
                errors++;
                $display("FAIL stream_drain c=%0d vld=%b src=%0d, want vld=%b src=%0d",
                         c, wvalid, wsrc, exp_wvalid, exp_wsrc);
            end
        end
    endtask

    task automatic test_reset_mid();
        memc_cmd_full = 1'b1;
        for (int c = 0; c < 5; c++) begin
            drive(2, rand_word());
            step();
            idle();
        end
        memc_cmd_full = 1'b0;
        step();
        checks++;
        if ({wvalid, wsrc, waddr} !== {exp_wvalid, exp_wsrc, exp_w.addr} || wvalid !== 1'b1) begin
            errors++;
            $display("FAIL mid_first vld=%b src=%0d addr=%h, want vld=1 src=%0d addr=%h",
                     wvalid, wsrc, waddr, exp_wsrc, exp_w.addr);
        end
        rstb = 1'b1;
        #1;
        model_reset();
        checks++;
        if ({wvalid, wsrc, wtag, waddr, wdata, req_full, ovf_err} !== '0) begin
            errors++;
            $display("FAIL mid_async_clear vld=%b src=%0d addr=%h full=%b ovf=%b, want all zero",
                     wvalid, wsrc, waddr, req_full, ovf_err);
        end
        @(posedge tb_clk);
        #1;
        rstb = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            checks++;
            if ({wvalid, waddr, req_full} !== {1'b0, exp_w.addr, exp_full}) begin
                errors++;
                $display("FAIL mid_no_stale c=%0d vld=%b addr=%h full=%b, want vld=0 addr=%h full=%b",
                         c, wvalid, waddr, req_full, exp_w.addr, exp_full);
            end
        end
    endtask

    task automatic test_random();
        logic [N-1:0] mask;
        apply_reset();
        for (int c = 0; c < 300; c++) begin
            idle();
            mask = 4'($urandom);
            for (int i = 0; i < N; i++) if (mask[i]) drive(i, rand_word());
            memc_cmd_full = ($urandom_range(0, 3) == 0);
            step();
            checks++;
            if ({wvalid, wsrc, wtag, waddr, wdata, req_full, ovf_err} !==
                {exp_wvalid, exp_wsrc, exp_w, exp_full, exp_ovf}) begin
                errors++;
                $display("FAIL random c=%0d vld=%b src=%0d addr=%h full=%b ovf=%b, want vld=%b src=%0d addr=%h full=%b ovf=%b",
                         c, wvalid, wsrc, waddr, req_full, ovf_err,
                         exp_wvalid, exp_wsrc, exp_w.addr, exp_full, exp_ovf);
            end
        end
        idle();
        memc_cmd_full = 1'b0;
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rstb          = 1'b1;
        req_wdata     = '0;
        req_wtag      = '0;
        req_waddr     = '0;
        req_wvalid    = '0;
        memc_cmd_full = 1'b0;
        model_reset();
        test_reset();
        test_single();
        test_all_four();
        test_stall();
        test_overflow();
        test_stream();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
